// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the Hi/Lo multiply/divide unit and the EX result-select mux.
package hilo_muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_HI  = 2'b01;
    localparam logic [1:0] SEL_LO  = 2'b10;
    localparam logic [1:0] SEL_SHT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/hilo_muldiv_unit_step.sv
// One combinational iteration: shift-add multiply or restoring trial-subtract divide.
module hilo_muldiv_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic           fits;

    always_comb begin
        sum      = {1'b0, acc} + (q[0] ? {1'b0, operand} : '0);
        rem_sh   = {acc, q[WIDTH-1]};
        fits     = (rem_sh >= {1'b0, operand});
        acc_next = sum[WIDTH:1];
        q_next   = {sum[0], q[WIDTH-1:1]};
        if (is_div) begin
            // Quotient bits enter at the bottom as the dividend shifts out the top.
            acc_next = fits ? WIDTH'(rem_sh - {1'b0, operand}) : rem_sh[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle unsigned MULTU/DIVU unit owning the Hi/Lo registers, with EX stall generation.
module hilo_muldiv_unit
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ITER  = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       rd_sel,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(ITER);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg;
    logic               is_div_reg;
    logic [WIDTH-1:0]   acc_reg, q_reg, operand_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic [WIDTH-1:0]   acc_next, q_next;
    logic               accept, accept_md, last_iter, reads_hilo;

    assign accept     = start && (state_reg != RUN);
    assign accept_md  = accept && !op[1];
    assign last_iter  = (state_reg == RUN) && (count_reg == CNT_W'(ITER - 1));
    assign reads_hilo = (rd_sel == SEL_HI) || (rd_sel == SEL_LO);

    hilo_muldiv_unit_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_reg),
        .acc      (acc_reg),
        .q        (q_reg),
        .operand  (operand_reg),
        .acc_next (acc_next),
        .q_next   (q_next)
    );

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE, FIN: state_next = accept_md ? RUN : IDLE;
            RUN:       state_next = last_iter ? FIN : RUN;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg   <= '0;
            is_div_reg  <= 1'b0;
            acc_reg     <= '0;
            q_reg       <= '0;
            operand_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            if (accept_md) begin
                count_reg   <= '0;
                is_div_reg  <= (op == OP_DIVU);
                acc_reg     <= '0;
                q_reg       <= src_a;
                operand_reg <= src_b;
            end else if (state_reg == RUN) begin
                count_reg <= count_reg + CNT_W'(1);
                acc_reg   <= acc_next;
                q_reg     <= q_next;
                if (last_iter) begin
                    hi_reg <= acc_next;
                    lo_reg <= q_next;
                end
            end
            if (accept && op == OP_MTHI) hi_reg <= src_a;
            if (accept && op == OP_MTLO) lo_reg <= src_a;
        end
    end

    assign busy   = (state_reg == RUN);
    assign done   = (state_reg == FIN);
    assign stall  = (busy && reads_hilo) || (start && !op[1] && reads_hilo);
    assign hi_out = hi_reg;
    assign lo_out = lo_reg;

    // EX should be stalled while busy, so a start here points at a pipeline bug.
    start_while_busy: assert property (@(posedge clk) disable iff (!rst_n) !(start && busy))
        else $warning("start ignored while unit is busy");

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized self-checking bench for hilo_muldiv_unit against an arithmetic Hi/Lo model.
module tb_hilo_muldiv_unit;
    import hilo_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic [1:0]  rd_sel;
    logic        busy, done, stall;
    logic [31:0] hi_out, lo_out;

    logic [31:0] hi_m, lo_m;
    int          chk_cnt  = 0;
    int          pass_cnt = 0;

    hilo_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .rd_sel (rd_sel),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
    endtask

    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o == OP_MULTU) return {32'd0, a} * {32'd0, b};
        if (b == 32'd0)    return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    task automatic move_to(input logic [1:0] o, input logic [31:0] a);
        start = 1'b1; op = o; src_a = a; rd_sel = SEL_ALU;
        #1;
        check_val("mt_stall", {63'd0, stall}, 64'd0);
        tick();
        if (o == OP_MTHI) hi_m = a; else lo_m = a;
        check_val("mt_hi", {32'd0, hi_out}, {32'd0, hi_m});
        check_val("mt_lo", {32'd0, lo_out}, {32'd0, lo_m});
        check_val("mt_busy", {62'd0, busy, done}, 64'd0);
    endtask

    // Issues MULTU/DIVU now; returns sampled in the done cycle. inject>=0 pulses a stray start.
    task automatic run_muldiv(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] rd, input int inject);
        logic        hl;
        logic [63:0] res;
        hl  = (rd == SEL_HI) || (rd == SEL_LO);
        res = ref_result(o, a, b);
        start = 1'b1; op = o; src_a = a; src_b = b; rd_sel = rd;
        #1;
        check_val("start_stall", {63'd0, stall}, {63'd0, hl});
        tick();
        for (int i = 0; i < 32; i++) begin
            check_val("run_busy", {62'd0, busy, done}, 64'd2);
            check_val("run_stall", {63'd0, stall}, {63'd0, hl});
            check_val("run_hilo", {hi_out, lo_out}, {hi_m, lo_m});
            if (i == inject) begin
                start = 1'b1; op = OP_MULTU; src_a = $urandom; src_b = $urandom;
            end
            tick();
        end
        {hi_m, lo_m} = res;
        check_val("fin_done", {62'd0, busy, done}, 64'd1);
        check_val("fin_stall", {63'd0, stall}, 64'd0);
        check_val("fin_hilo", {hi_out, lo_out}, {hi_m, lo_m});
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h", o, a, b, hi_out, lo_out);
    endtask

    task automatic idle_tick();
        rd_sel = SEL_ALU;
        tick();
        check_val("idle_state", {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; op = OP_MULTU; src_a = '0; src_b = '0; rd_sel = SEL_ALU;
        hi_m = '0; lo_m = '0;
        #1;
        check_val("rst_hilo", {hi_out, lo_out}, 64'd0);
        check_val("rst_flags", {61'd0, busy, done, stall}, 64'd0);
        #11 rst_n = 1'b1;
        tick();
        check_val("idle_hilo", {hi_out, lo_out}, 64'd0);
        check_val("idle_flags", {61'd0, busy, done, stall}, 64'd0);

        move_to(OP_MTHI, 32'h1234_5678);
        move_to(OP_MTLO, 32'hCAFE_0001);

        run_muldiv(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, SEL_HI, -1);
        idle_tick();
        run_muldiv(OP_DIVU, 32'd100, 32'd7, SEL_LO, -1);
        idle_tick();
        run_muldiv(OP_DIVU, 32'd5, 32'd0, SEL_ALU, -1);
        idle_tick();

        // Back-to-back: second op issued in the FIN cycle of the first.
        run_muldiv(OP_DIVU, 32'd9, 32'd2, SEL_ALU, -1);
        run_muldiv(OP_MULTU, 32'd3, 32'd4, SEL_ALU, -1);
        idle_tick();

        // Stray start mid-run must not disturb the operation in flight.
        run_muldiv(OP_DIVU, 32'hDEAD_BEEF, 32'd13, SEL_HI, 9);
        idle_tick();

        for (int n = 0; n < 10; n++) begin
            ro = ($urandom_range(0, 1) == 0) ? OP_MULTU : OP_DIVU;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            run_muldiv(ro, ra, rb, 2'($urandom_range(0, 3)), -1);
            idle_tick();
            if (n % 3 == 0) move_to(2'($urandom_range(2, 3)), $urandom);
        end

        // Reset mid-run: DIVU 1000/3, stray MULTU at cycle 10, reset at cycle 20.
        start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3; rd_sel = SEL_ALU;
        tick();
        for (int c = 1; c < 20; c++) begin
            if (c == 10) begin
                start = 1'b1; op = OP_MULTU; src_a = 32'd2; src_b = 32'd2;
            end
            tick();
        end
        check_val("pre_rst_busy", {63'd0, busy}, 64'd1);
        check_val("pre_rst_hilo", {hi_out, lo_out}, {hi_m, lo_m});
        rst_n = 1'b0;
        #1;
        hi_m = '0; lo_m = '0;
        check_val("async_rst_flags", {62'd0, busy, done}, 64'd0);
        check_val("async_rst_hilo", {hi_out, lo_out}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("rst_hold_done", {63'd0, done}, 64'd0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 36; c++) begin
            tick();
            check_val("post_rst_idle", {62'd0, busy, done}, 64'd0);
        end
        check_val("post_rst_hilo", {hi_out, lo_out}, 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
